apple1_kbd_port: RTL and testbench

- Keyboard register port that sits between the PS/2 scancode-to-ASCII decoder (upstream) and the 6502 data-in mux (downstream).
- Buffers decoded ASCII keys in a small FIFO so fast typing and pasted text are not lost.
- Presents Apple-1 PIA-style KBD (0xD010) and KBDCR (0xD011) read registers to the CPU.
- Pops one character per CPU read of KBD, qualified by the CPU clock enable.

---
 rtl/apple1_kbd_pkg.sv | 21 ++
 rtl/apple1_kbd_fifo.sv | 75 +++++++
 rtl/apple1_kbd_port.sv | 89 ++++++++
 tb/tb_apple1_kbd_port.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_kbd_pkg.sv
// Shared constants and helpers for the Apple-1 keyboard register port.
package apple1_kbd_pkg;

    localparam logic [15:0] KBD_ADDR   = 16'hD010;
    localparam logic [15:0] KBDCR_ADDR = 16'hD011;

    // Register select as seen on the single address line of the port
    localparam logic ADDR_KBD   = 1'b0;
    localparam logic ADDR_KBDCR = 1'b1;

    localparam logic [6:0] ASCII_CR = 7'h0D;

    // Fold lowercase ASCII to uppercase; the Apple-1 monitor only understands uppercase.
    function automatic logic [6:0] upcase7(input logic [6:0] c);
        if (c >= 7'h61 && c <= 7'h7A) begin
            return c - 7'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/apple1_kbd_fifo.sv
// DEPTH x WIDTH synchronous FIFO for decoded keys. A pop on a full FIFO frees
// a slot in the same cycle, so a simultaneous push is accepted. Flush wins
// over any same-cycle push or pop.
module apple1_kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic                       clk14,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apple1_kbd_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem[rd_ptr];

    // Pop is ignored on empty; push on full only goes through when a pop frees a slot.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents beyond the valid window are don't-care, so no reset.
    always_ff @(posedge clk14) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/apple1_kbd_port.sv
// Apple-1 PIA-style keyboard port: buffers decoded ASCII keys and presents
// them as the KBD / KBDCR read registers. A KBD read on an enabled CPU cycle
// consumes one key; an empty KBD read returns the last consumed key with bit 7 clear.
module apple1_kbd_port
    import apple1_kbd_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int UPCASE = 1
) (
    input  logic       clk14,
    input  logic       rst_n,
    input  logic       key_strobe,
    input  logic [6:0] key_data,
    input  logic       flush,
    input  logic       cpu_clken,
    input  logic       cs,
    input  logic       address,
    input  logic       we,
    output logic [7:0] dout,
    output logic       key_avail,
    output logic       overflow
);

    logic [6:0]             push_char;
    logic [6:0]             head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop_req;
    logic                   pop_ok;
    logic                   drop;
    logic [6:0]             last_char;

    assign push_char = (UPCASE != 0) ? upcase7(key_data) : key_data;
    assign pop_req   = cs & cpu_clken & ~we & (address == ADDR_KBD);
    assign pop_ok    = pop_req & ~fifo_empty;
    // A key is lost only when the FIFO is full and no pop frees a slot this cycle.
    assign drop      = key_strobe & fifo_full & ~pop_ok;
    assign key_avail = (fifo_count != '0);

    apple1_kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (7)
    ) u_fifo (
        .clk14   (clk14),
        .rst_n   (rst_n),
        .push    (key_strobe),
        .pop     (pop_req),
        .flush   (flush),
        .wr_data (push_char),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Remember the most recently consumed key; flush discards a same-cycle pop.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            last_char <= 7'h00;
        end else if (pop_ok && !flush) begin
            last_char <= head;
        end
    end

    // Sticky overflow flag, cleared only by flush or reset.
    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Read mux for KBD / KBDCR.
    always_comb begin
        dout = 8'h00;
        if (address == ADDR_KBDCR) begin
            dout = {key_avail, 7'b0};
        end else if (key_avail) begin
            dout = {1'b1, head};
        end else begin
            dout = {1'b0, last_char};
        end
    end

endmodule

// File: tb/tb_apple1_kbd_port.sv
// Self-checking bench for apple1_kbd_port against a queue-based reference model.
module tb_apple1_kbd_port;

    localparam int DEPTH = 8;

    logic       clk14 = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_strobe = 1'b0;
    logic [6:0] key_data = 7'h00;
    logic       flush = 1'b0;
    logic       cpu_clken = 1'b0;
    logic       cs = 1'b0;
    logic       address = 1'b0;
    logic       we = 1'b0;
    logic [7:0] dout;
    logic       key_avail;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [6:0] q[$];
    logic [6:0] m_last = 7'h00;
    logic       m_ovf = 1'b0;

    apple1_kbd_port #(.DEPTH(DEPTH), .UPCASE(1)) dut (
        .clk14      (clk14),
        .rst_n      (rst_n),
        .key_strobe (key_strobe),
        .key_data   (key_data),
        .flush      (flush),
        .cpu_clken  (cpu_clken),
        .cs         (cs),
        .address    (address),
        .we         (we),
        .dout       (dout),
        .key_avail  (key_avail),
        .overflow   (overflow)
    );

    always #35 clk14 = ~clk14;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] fold(input logic [6:0] c);
        if (c >= 7'h61 && c <= 7'h7A) return c & 7'h5F;
        return c;
    endfunction

    function automatic logic [7:0] exp_kbd();
        if (q.size() != 0) return {1'b1, q[0]};
        return {1'b0, m_last};
    endfunction

    function automatic logic [7:0] exp_kbdcr();
        return {(q.size() != 0), 7'b0};
    endfunction

    task automatic model_step(input logic s, input logic [6:0] d, input logic fl, input logic pr);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (pr && q.size() != 0) m_last = q.pop_front();
            if (s) begin
                if (q.size() < DEPTH) q.push_back(fold(d));
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last = 7'h00;
        m_ovf = 1'b0;
    endtask

    // One clk14 cycle with the given bus/keyboard inputs; rd is dout just before the edge.
    task automatic clk_cycle(input logic s, input logic [6:0] d, input logic fl, input logic en,
                             input logic c, input logic a, input logic w, output logic [7:0] rd);
        key_strobe = s; key_data = d; flush = fl; cpu_clken = en; cs = c; address = a; we = w;
        #1 rd = dout;
        @(posedge clk14);
        model_step(s, d, fl, en & c & ~w & ~a);
        #1;
        key_strobe = 1'b0; flush = 1'b0; cpu_clken = 1'b0;
    endtask

    task automatic peek(input logic a, output logic [7:0] v);
        cs = 1'b0; cpu_clken = 1'b0; we = 1'b0; address = a;
        #1 v = dout;
    endtask

    task automatic push_key(input logic [6:0] d);
        logic [7:0] rd;
        clk_cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd);
    endtask

    task automatic do_flush();
        logic [7:0] rd;
        clk_cycle(1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        model_reset();
        vectors++; if (key_avail !== 1'b0) begin miscompares++; $display("FAIL reset_key_avail: got %b expected 0", key_avail); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        peek(1'b0, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reset_kbd: got %h expected 00", v); end
        peek(1'b1, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL reset_kbdcr: got %h expected 00", v); end
        #13 rst_n = 1'b1;
        @(posedge clk14); #1;
    endtask

    task automatic test_single_key();
        logic [7:0] v, rd;
        push_key(7'h61);
        vectors++; if (key_avail !== 1'b1) begin miscompares++; $display("FAIL single_avail: got %b expected 1", key_avail); end
        peek(1'b1, v);
        vectors++; if (v !== 8'h80) begin miscompares++; $display("FAIL single_kbdcr: got %h expected 80", v); end
        clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
        vectors++; if (rd !== 8'hC1) begin miscompares++; $display("FAIL single_kbd_read: got %h expected c1", rd); end
        vectors++; if (key_avail !== 1'b0) begin miscompares++; $display("FAIL single_avail_after: got %b expected 0", key_avail); end
        peek(1'b1, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL single_kbdcr_after: got %h expected 00", v); end
    endtask

    task automatic test_sequence();
        logic [7:0] rd;
        logic [7:0] want [4];
        want[0] = 8'hC8; want[1] = 8'hC9; want[2] = 8'h8D; want[3] = 8'h0D;
        push_key(7'h48);
        push_key(7'h49);
        push_key(7'h0D);
        for (int i = 0; i < 4; i++) begin
            clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
            vectors++; if (rd !== want[i]) begin miscompares++; $display("FAIL seq_read%0d: got %h expected %h", i, rd, want[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rd, e;
        do_flush();
        for (int i = 0; i < 9; i++) begin
            push_key(7'($urandom_range(7'h20, 7'h7E)));
            if (i == 7) begin
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_after8: got %b expected 0", overflow); end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_after9: got %b expected 1", overflow); end
        for (int i = 0; i < 8; i++) begin
            e = exp_kbd();
            clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
            vectors++; if (rd !== e || rd[7] !== 1'b1) begin miscompares++; $display("FAIL ovf_read%0d: got %h expected %h", i, rd, e); end
        end
        vectors++; if (key_avail !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got %b expected 0", key_avail); end
        do_flush();
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_flush: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] rd, e;
        do_flush();
        for (int i = 0; i < DEPTH; i++) push_key(7'($urandom_range(7'h20, 7'h7E)));
        e = exp_kbd();
        clk_cycle(1'b1, 7'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
        vectors++; if (rd !== e) begin miscompares++; $display("FAIL fullpp_read: got %h expected %h", rd, e); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp_ovf: got %b expected 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_kbd();
            clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
            vectors++; if (rd !== e || rd[7] !== 1'b1) begin miscompares++; $display("FAIL fullpp_drain%0d: got %h expected %h", i, rd, e); end
        end
        clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
        vectors++; if (rd !== 8'h5A) begin miscompares++; $display("FAIL fullpp_empty: got %h expected 5a", rd); end
    endtask

    task automatic test_clken_hold();
        logic [7:0] rd, v;
        do_flush();
        push_key(7'h50);
        push_key(7'h71);
        for (int i = 0; i < 14; i++) begin
            clk_cycle(1'b0, 7'h00, 1'b0, (i == 5), 1'b1, 1'b0, 1'b0, rd);
        end
        peek(1'b0, v);
        vectors++; if (v !== 8'hD1) begin miscompares++; $display("FAIL hold_one_pop: got %h expected d1", v); end
        clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rd);
        peek(1'b0, v);
        vectors++; if (v !== 8'hD1) begin miscompares++; $display("FAIL write_no_pop: got %h expected d1", v); end
        vectors++; if (key_avail !== 1'b1) begin miscompares++; $display("FAIL write_avail: got %b expected 1", key_avail); end
    endtask

    task automatic test_async_reset();
        logic [7:0] rd, v;
        do_flush();
        for (int i = 0; i < 9; i++) push_key(7'($urandom_range(7'h20, 7'h7E)));
        for (int i = 0; i < 4; i++) clk_cycle(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rd);
        vectors++; if (overflow !== 1'b1 || key_avail !== 1'b1) begin miscompares++; $display("FAIL arst_pre: got ovf=%b avail=%b expected 1 1", overflow, key_avail); end
        #10 rst_n = 1'b0;
        #1;
        model_reset();
        vectors++; if (key_avail !== 1'b0) begin miscompares++; $display("FAIL arst_avail: got %b expected 0", key_avail); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL arst_ovf: got %b expected 0", overflow); end
        #15 rst_n = 1'b1;
        @(posedge clk14); #1;
        peek(1'b0, v);
        vectors++; if (v !== 8'h00) begin miscompares++; $display("FAIL arst_kbd: got %h expected 00", v); end
    endtask

    task automatic test_random();
        logic [7:0] rd, e;
        logic s, fl, en, c, a, w;
        logic [6:0] d;
        for (int i = 0; i < 400; i++) begin
            s  = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 99) < 3);
            en = ($urandom_range(0, 99) < 60);
            c  = ($urandom_range(0, 99) < 45);
            a  = ($urandom_range(0, 99) < 20);
            w  = ($urandom_range(0, 99) < 15);
            d  = 7'($urandom_range(0, 127));
            e  = a ? exp_kbdcr() : exp_kbd();
            clk_cycle(s, d, fl, en, c, a, w, rd);
            vectors++; if (rd !== e) begin miscompares++; $display("FAIL rand_dout%0d: got %h expected %h", i, rd, e); end
            vectors++; if (key_avail !== (q.size() != 0)) begin miscompares++; $display("FAIL rand_avail%0d: got %b expected %b", i, key_avail, (q.size() != 0)); end
            vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_ovf%0d: got %b expected %b", i, overflow, m_ovf); end
        end
    endtask

    initial begin
        #20;
        test_reset();
        test_single_key();
        test_sequence();
        test_overflow();
        test_full_push_pop();
        test_clken_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
